// File: rtl/spi_pkg.sv
// Shared SPI receiver types: FSM state encoding and synchronizer idle levels.
package spi_pkg;
  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} spi_state_e;

  localparam logic SCK_IDLE  = 1'b0;
  localparam logic CS_N_IDLE = 1'b1;
  localparam logic MOSI_IDLE = 1'b0;
endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer with a configurable reset level.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/spi_mosi_rx.sv
// SPI mode-0 MOSI receiver: oversampled sck, MSB-first words, valid/ready holding register.
// Define SPI_MOSI_RX_OVERRUN_EN to drop words that arrive while data_out is unconsumed and flag overrun.
module spi_mosi_rx
  import spi_pkg::*;
#(
  parameter int SIZE = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            sck,
  input  logic            cs_n,
  input  logic            mosi,
  output logic [SIZE-1:0] data_out,
  output logic            data_valid,
  input  logic            data_ready,
  output logic            frame_active,
  output logic            overrun,
  input  logic            overrun_clr
);
  localparam int CW = $clog2(SIZE);

  logic sck_s, cs_n_s, mosi_s;
  logic sck_q, sck_rise;

  sync_2ff #(.RST_VAL(SCK_IDLE))  u_sync_sck  (.clk(clk), .rst_n(rst_n), .d(sck),  .q(sck_s));
  sync_2ff #(.RST_VAL(CS_N_IDLE)) u_sync_cs_n (.clk(clk), .rst_n(rst_n), .d(cs_n), .q(cs_n_s));
  sync_2ff #(.RST_VAL(MOSI_IDLE)) u_sync_mosi (.clk(clk), .rst_n(rst_n), .d(mosi), .q(mosi_s));

  assign sck_rise = sck_s & ~sck_q;

  spi_state_e      state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic [SIZE-1:0] shreg_q;
  logic            done_q;
  logic [1:0]      prime_q;
  logic            armed_q;
  logic            drop, take;

  // armed_q blocks a frame already in progress at reset release: cs_n must be seen
  // high (after the synchronizer has flushed its reset value) before SHIFT is allowed.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!cs_n_s && armed_q) state_d = SHIFT;
      SHIFT:   if (cs_n_s)             state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  assign frame_active = (state_q == SHIFT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_q   <= SCK_IDLE;
      prime_q <= '0;
      armed_q <= 1'b0;
      cnt_q   <= '0;
      shreg_q <= '0;
      done_q  <= 1'b0;
    end else begin
      sck_q   <= sck_s;
      prime_q <= {prime_q[0], 1'b1};
      if (cs_n_s && prime_q[1]) armed_q <= 1'b1;
      done_q  <= 1'b0;
      if (state_q == IDLE) begin
        cnt_q   <= '0;
        shreg_q <= '0;
      end else if (sck_rise) begin
        shreg_q <= {shreg_q[SIZE-2:0], mosi_s};
        if (cnt_q == CW'(SIZE-1)) begin
          cnt_q  <= '0;
          done_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  assign take = data_valid & data_ready;

`ifdef SPI_MOSI_RX_OVERRUN_EN
  assign drop = done_q & data_valid & ~data_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           overrun <= 1'b0;
    else if (drop)        overrun <= 1'b1;
    else if (overrun_clr) overrun <= 1'b0;
  end
`else
  logic unused_clr;
  assign unused_clr = overrun_clr;
  assign drop       = 1'b0;
  assign overrun    = 1'b0;
`endif

  // done_q lags the wrapping edge by one cycle, so shreg_q already holds the full word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out   <= '0;
      data_valid <= 1'b0;
    end else if (done_q && !drop) begin
      data_out   <= shreg_q;
      data_valid <= 1'b1;
    end else if (take) begin
      data_valid <= 1'b0;
    end
  end
endmodule

// File: doc/spi_mosi_rx.md
SPI_MOSI_RX -- requirements
Module: spi_mosi_rx

Interface
REQ-001 SHALL have parameter SIZE, default 8, meaning word width in bits; legal range 2..32.
REQ-002 SHALL have port clk, input, 1, system clock; the only clock in the block.
REQ-003 SHALL have port rst_n, input, 1, reset; asynchronous and active-low.
REQ-004 SHALL have port sck, input, 1, serial clock from the remote transmitter; asynchronous to clk.
REQ-005 SHALL have port cs_n, input, 1, frame select, active-low; asynchronous.
REQ-006 SHALL have port mosi, input, 1, serial data; changes on the falling edge of sck, MSB first.
REQ-007 SHALL have port data_out, output, SIZE, received word holding register.
REQ-008 SHALL have port data_valid, output, 1, data_out holds an unconsumed word.
REQ-009 SHALL have port data_ready, input, 1, consumer accepts the word when data_valid=1.
REQ-010 SHALL have port frame_active, output, 1, receiver is in the SHIFT state.
REQ-011 SHALL have port overrun, output, 1, sticky flag: a completed word was lost.
REQ-012 SHALL have port overrun_clr, input, 1, clears overrun.

Function
REQ-013 SHALL pass sck, cs_n and mosi each through a 2-flop synchronizer before any use.
REQ-014 SHALL detect an sck rising edge as the synchronized sck at 1 with its previous registered value at 0; falling edges are ignored.
REQ-015 SHALL implement an FSM with two states:
- IDLE -> SHIFT when synchronized cs_n=0.
- SHIFT -> IDLE when synchronized cs_n=1.
REQ-016 SHALL, in SHIFT on each rising edge, shift the synchronized mosi into the LSB of the shift register (MSB first) and increment the bit counter.
REQ-017 SHALL size the bit counter as clog2(SIZE) bits and wrap it to 0 when it reaches SIZE-1; one frame may carry back-to-back words.
REQ-018 SHALL, when the counter wraps, load the completed word into data_out and set data_valid on the next clk edge (one cycle after edge detect).
REQ-019 SHALL clear data_valid on a clk edge where data_valid=1 and data_ready=1; data_out holds its value while data_valid=1.
REQ-020 SHALL, when a word completes and data_ready=1 in the same cycle, load the new word and keep data_valid=1 (consume and refill).
REQ-021 SHALL, on cs_n deassertion mid-word, discard the partial word, clear the counter and shift register, and leave data_out and data_valid unchanged.
REQ-022 SHALL ignore sck edges in IDLE.
REQ-023 SHALL drive frame_active=1 exactly while in SHIFT.
REQ-024 SHALL require clk >= 4x the sck frequency; slower clk is outside the specified range.

Reset
REQ-025 SHALL, on rst_n=0, immediately force: state IDLE; counter, shift register and data_out = 0; data_valid = 0; frame_active = 0; overrun = 0; synchronizer flops = idle levels (sck 0, cs_n 1, mosi 0).
REQ-026 SHALL, when reset occurs mid-frame, resume only after cs_n is seen high then low again.

Configuration
REQ-027 SHALL use the macro SPI_MOSI_RX_OVERRUN_EN.
- Defined: a word completing while data_valid=1 and data_ready=0 is dropped, data_out is preserved, and overrun is set. overrun_clr=1 clears it; a simultaneous set wins.
- Undefined: the new word overwrites data_out, overrun is tied to 0, and overrun_clr is ignored.

Structure
REQ-028 SHALL take the FSM state typedef (IDLE, SHIFT) and the synchronizer idle-level constants from shared package spi_pkg.
REQ-029 SHALL instantiate the sub-module sync_2ff (parameterized reset value) once per asynchronous input.

Verification
REQ-030 SHALL pass: SIZE=8, clk=50 MHz, sck=5 MHz, frame sending 0xA5, data_ready=1 -> data_valid pulses 1 cycle with data_out=0xA5 and overrun=0.
REQ-031 SHALL pass: one frame sending 0x3C then 0xC3, data_ready=1 -> two valid pulses, 0x3C then 0xC3.
REQ-032 SHALL pass: cs_n raised after 5 bits of 0xFF, then a frame sending 0x12 -> a single word 0x12 and no spurious valid.
REQ-033 SHALL pass, with the macro defined: 0x11 then 0x22 with data_ready=0 -> data_out=0x11 and overrun=1. Then overrun_clr pulse -> overrun=0.
REQ-034 SHALL pass, with the macro undefined: the same stimulus as REQ-033 -> data_out=0x22, data_valid=1 and overrun=0.
REQ-035 SHALL pass: rst_n asserted after 4 bits -> all outputs 0 within the same cycle. Then a fresh frame sending 0x5A -> data_out=0x5A.
